updn_count_seq: RTL
===================

// Module: updn_count_seq
// PURPOSE
//  Command-driven sequencer for the up/down counter datapath: accepts target-value commands over a
//  valid/ready handshake and steps the counter one LSB per cycle toward the target, or loads it directly.
//  Sits between a control FSM/CPU-side register block and the counter; reports busy/done/aborted status.
// PARAMETERS
//  W        4    counter and target width in bits
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, asynchronous, active-low
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   sequencer can accept a command
//  cmd_target   in   W   target count value
//  cmd_load     in   1   1 = load target directly; 0 = step toward target
//  pause        in   1   hold count while RUN (level)
//  abort        in   1   terminate RUN, keep current count (level, sampled each cycle)
//  count        out  W   current counter value
//  up_dn        out  1   current step direction: 1 = up, 0 = down
//  busy         out  1   high while in RUN
//  done         out  1   one-cycle pulse: command completed normally
//  aborted      out  1   one-cycle pulse: command terminated by abort
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, state=IDLE, cmd_ready=1, busy=0, done=0, aborted=0, up_dn=1.
//  - States: IDLE, RUN, DONE. Handshake fires on an edge where cmd_valid & cmd_ready; commands
//    presented while cmd_ready=0 are ignored (not queued). cmd_ready=1 only in IDLE.
//  - IDLE, accept (edge E0):
//      cmd_load=1            -> count<=cmd_target at E0, state<=DONE.
//      cmd_target==count     -> state<=DONE, count unchanged (zero-distance command).
//      else                  -> latch target, up_dn<=(cmd_target>count), state<=RUN.
//  - RUN: each edge with pause=0 and abort=0, count <= count +/- 1 per up_dn. Edge on which new count
//    equals latched target -> state<=DONE. Distance d command: count updates at E1..Ed, done high in the
//    cycle after Ed, cmd_ready high again from Ed+1. Steps never wrap: direction always chosen so the
//    target is reached monotonically (e.g. 15 -> 0 takes 15 down-steps).
//  - pause=1 in RUN: count and up_dn hold, busy stays 1; pause ignored outside RUN.
//  - abort=1 in RUN: priority over pause and stepping; count holds, state<=IDLE, aborted pulses one
//    cycle, done not asserted. abort ignored in IDLE/DONE.
//  - DONE: lasts exactly one cycle, done=1, cmd_ready=0, busy=0, then IDLE.
//  - busy=1 iff state==RUN; done and aborted never high together.
//  - Reset mid-operation: all state cleared immediately; no done/aborted pulse generated.
//  - All outputs registered or decoded from registered state only; no combinational in->out paths
//    except none (cmd_ready is a pure state decode).
// STRUCTURE
//  - Shared package: state encoding constants S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10; default W.
//  - One sub-module: updn_cnt_core (W-bit up/down counter with en, up_dn, load, load_val,
//    async active-low rst); sequencer holds FSM, target register and status pulses.
// TESTING
//  1. Reset: assert rst=0 mid-RUN at count=6 -> count=0, busy=0, cmd_ready=1 immediately, no pulses.
//  2. Up run: count=3, cmd target=9 load=0 -> up_dn=1, count 4..9 on 6 edges, done 1 cycle, then ready.
//  3. Down with pause: count=9, target=2, pause 2 cycles at count=6 -> count holds 6, reaches 2 after
//     9 edges total, up_dn=0, single done pulse.
//  4. Load: count=1, target=12 load=1 -> count=12 next edge, no intermediate values, done pulse.
//  5. Abort: count=9, target=0, abort when count=5 (pause also high) -> count stays 5, aborted 1 cycle,
//     done=0, back to IDLE; next command from 5 works.
//  6. Edges: target==count -> done after 1 cycle, no step; count=15 target=0 -> 15 down-steps, no wrap;
//     cmd_valid pulses during RUN ignored (target unchanged).

Source files
------------

// File: rtl/updn_count_seq_pkg.sv
// Shared definitions for the up/down counter sequencer: state encoding and default width.
package updn_count_seq_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/updn_count_seq_if.sv
// Command/status bundle between a controller (master) and the counter sequencer (slave).
interface updn_count_seq_if #(
  parameter int W = updn_count_seq_pkg::W_DEF
);

  // A command transfers on a rising edge where cmd_valid & cmd_ready; cmd_target/cmd_load are
  // sampled on that edge only. A command offered while cmd_ready=0 is dropped, not queued.
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [W-1:0]                  cmd_target;
  logic                          cmd_load;
  logic                          pause;
  logic                          abort;
  logic [W-1:0]                  count;
  logic                          up_dn;
  logic                          busy;
  logic                          done;
  logic                          aborted;
  updn_count_seq_pkg::state_t    st;

  modport master (
    output cmd_valid, cmd_target, cmd_load, pause, abort,
    input  cmd_ready, count, up_dn, busy, done, aborted, st
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_load, pause, abort,
    output cmd_ready, count, up_dn, busy, done, aborted, st
  );

endinterface

// File: rtl/updn_count_seq_core.sv
// W-bit up/down counter: load has priority over a single step in the up_dn direction.
module updn_cnt_core #(
  parameter int W = updn_count_seq_pkg::W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up_dn ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/updn_count_seq.sv
// Sequencer: accepts target commands and walks the counter core one step per cycle toward them.
module updn_count_seq
  import updn_count_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  updn_count_seq_if.slave   bus
);

  state_t         state_q, state_d;
  logic [W-1:0]   tgt_q, tgt_d;
  logic           up_q, up_d;
  logic           aborted_q, aborted_d;
  logic           cnt_en;
  logic           cnt_ld;
  logic [W-1:0]   cnt_val;
  logic [W-1:0]   step_val;

  updn_cnt_core #(.W(W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .up_dn    (up_q),
    .load     (cnt_ld),
    .load_val (bus.cmd_target),
    .count    (cnt_val)
  );

  assign step_val = up_q ? cnt_val + 1'b1 : cnt_val - 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tgt_q     <= '0;
      up_q      <= 1'b1;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      up_q      <= up_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    up_d      = up_q;
    aborted_d = 1'b0;
    cnt_en    = 1'b0;
    cnt_ld    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_load) begin
            cnt_ld  = 1'b1;
            state_d = S_DONE;
          end else if (bus.cmd_target == cnt_val) begin
            state_d = S_DONE;
          end else begin
            // Direction is fixed at accept so the walk is monotonic and never wraps.
            tgt_d   = bus.cmd_target;
            up_d    = (bus.cmd_target > cnt_val);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (!bus.pause) begin
          cnt_en = 1'b1;
          if (step_val == tgt_q) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.aborted   = aborted_q;
  assign bus.count     = cnt_val;
  assign bus.up_dn     = up_q;
  assign bus.st        = state_q;

endmodule
